// File: rtl/solver_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// solver_ctrl_pkg
// Shared definitions for the solver start controller: FSM state encoding,
// Avalon-MM word addresses and the bit positions inside STATUS and CONTROL.
// -----------------------------------------------------------------------------
package solver_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GO   = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Word addresses
    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
    localparam logic [1:0] ADDR_CYCLES  = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_START   = 4;

    // CONTROL bit positions
    localparam int CTL_SW_START = 0;
    localparam int CTL_HW_EN    = 1;
    localparam int CTL_IRQ_EN   = 2;

endpackage

// File: rtl/solver_sync_edge.sv
// -----------------------------------------------------------------------------
// solver_sync_edge
// Multi-stage synchroniser for an asynchronous level, followed by a
// rising-edge detector working on the synchronised level.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   d            : asynchronous input
//   level        : synchronised copy of d (SYNC_STAGES clocks of latency)
//   rise         : high for one cycle after level goes 0 -> 1
// -----------------------------------------------------------------------------
module solver_sync_edge
    import solver_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    // NOTE: sequential state is always assigned with non-blocking (<=) so every
    // flop samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
            level_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    // Combinational from two flops, so the edge is seen by the FSM at the very
    // next clock after the level first appears.
    assign rise  = level & ~level_q;

endmodule

// File: rtl/solver_start_ctrl.sv
// -----------------------------------------------------------------------------
// solver_start_ctrl
// Avalon-MM slave that sequences one run of the hardware solver: launch on a
// software write or a synchronised rising edge of start_in, one-cycle
// solver_go, wait for solver_done under a programmable timeout, measure the
// run length, and report through sticky status bits and a level interrupt.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   address/write/writedata/read/readdata : Avalon-MM slave, read latency 1
//   start_in             : asynchronous external start request
//   solver_done          : completion from the solver (pulse or level)
//   solver_go            : one-cycle launch pulse
//   solver_busy          : high while a run is in progress
//   irq                  : irq_en & (done | timeout)
// -----------------------------------------------------------------------------
module solver_start_ctrl
    import solver_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        start_in,
    input  logic        solver_done,
    output logic        solver_go,
    output logic        solver_busy,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] timeout_q;
    logic [CNT_W-1:0] cycles_q;
    logic             flag_done;
    logic             flag_timeout;
    logic             flag_overrun;
    logic             hw_en;
    logic             irq_en;
    logic             start_level;
    logic             start_rise;
    logic [31:0]      rd_mux;

    // Reads have no side effects; the strobe is not needed.
    logic unused_ok;
    assign unused_ok = &{1'b0, read};

    solver_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (start_in),
        .level   (start_level),
        .rise    (start_rise)
    );

    // Bus decode
    logic wr_status;
    logic wr_control;
    logic wr_timeout;
    logic sw_start;
    logic start_req;
    logic run_done;
    logic run_timeout;

    assign wr_status  = write && (address == ADDR_STATUS);
    assign wr_control = write && (address == ADDR_CONTROL);
    assign wr_timeout = write && (address == ADDR_TIMEOUT);

    // sw_start is a pure strobe: it is never stored, so it always reads 0.
    assign sw_start  = wr_control & writedata[CTL_SW_START];
    // Both sources merge into one request, so a coincident sw/hw start in IDLE
    // launches a single run and counts as one request.
    assign start_req = sw_start | (hw_en & start_rise);

    // Done has priority over the timeout compare. The timeout_q != 0 guard
    // keeps the -1 from wrapping into a match when the timeout is disabled.
    assign run_done    = (state == S_RUN) && solver_done;
    assign run_timeout = (state == S_RUN) && !solver_done &&
                         (timeout_q != '0) && (cnt == timeout_q - CNT_ONE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start_req) state_next = S_GO;
            S_GO:   state_next = S_RUN;
            S_RUN:  if (run_done || run_timeout) state_next = S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from state register only) -------
    always_comb begin
        solver_go   = (state == S_GO);
        solver_busy = (state != S_IDLE);
    end

    // ---------------- Counter, registers, sticky flags ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            timeout_q    <= '0;
            cycles_q     <= '0;
            flag_done    <= 1'b0;
            flag_timeout <= 1'b0;
            flag_overrun <= 1'b0;
            hw_en        <= 1'b0;
            irq_en       <= 1'b0;
            readdata     <= '0;
        end else begin
            if (state == S_IDLE && start_req) begin
                cnt <= '0;
            end else if (state == S_RUN && !run_done && !run_timeout &&
                         cnt != '1) begin
                cnt <= cnt + CNT_ONE;
            end

            if (run_done) begin
                cycles_q <= cnt;
            end

            // Sticky flags: a set in the same cycle as a W1C wins.
            flag_done    <= run_done |
                            (flag_done & ~(wr_status & writedata[ST_DONE]));
            flag_timeout <= run_timeout |
                            (flag_timeout & ~(wr_status & writedata[ST_TIMEOUT]));
            flag_overrun <= (start_req && state != S_IDLE) |
                            (flag_overrun & ~(wr_status & writedata[ST_OVERRUN]));

            if (wr_control) begin
                hw_en  <= writedata[CTL_HW_EN];
                irq_en <= writedata[CTL_IRQ_EN];
            end

            if (wr_timeout) begin
                timeout_q <= writedata[CNT_W-1:0];
            end

            readdata <= rd_mux;
        end
    end

    // ---------------- Read mux (registered into readdata every clock) -------
    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_STATUS: begin
                rd_mux[ST_BUSY]    = solver_busy;
                rd_mux[ST_DONE]    = flag_done;
                rd_mux[ST_TIMEOUT] = flag_timeout;
                rd_mux[ST_OVERRUN] = flag_overrun;
                rd_mux[ST_START]   = start_level;
            end
            ADDR_CONTROL: begin
                rd_mux[CTL_HW_EN]  = hw_en;
                rd_mux[CTL_IRQ_EN] = irq_en;
            end
            ADDR_TIMEOUT: rd_mux[CNT_W-1:0] = timeout_q;
            ADDR_CYCLES:  rd_mux[CNT_W-1:0] = cycles_q;
            default:      rd_mux = '0;
        endcase
    end

    assign irq = irq_en & (flag_done | flag_timeout);

endmodule
